// File: rtl/sw_debounce_events_pkg.sv
// Board-level constants and shared types for the switch debounce front end.
// DEBOUNCE_CYCLES is the default hold time that the top level uses for STABLE_CYCLES.
package sw_debounce_events_pkg;

    localparam int SW_WIDTH        = 16;
    localparam int CLK_HZ          = 100_000_000;
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } deb_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a vector of asynchronous inputs.
// There is deliberately no logic between the two flop stages.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= '0;
            q       <= '0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/sw_debounce_events.sv
// Slide-switch front end: synchronise, debounce the whole vector, and publish
// a clean level plus a coalescing valid/ready change-event stream.
module sw_debounce_events
    import sw_debounce_events_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] sw_clean,
    output logic             chg_valid,
    input  logic             chg_ready,
    output logic [WIDTH-1:0] chg_bits,
    output logic [WIDTH-1:0] chg_value
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;
    deb_state_t       state, state_nxt;
    logic [WIDTH-1:0] cand, cand_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] clean_nxt;
    logic             upd;
    logic [WIDTH-1:0] delta;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (SW),
        .q   (sync_q)
    );

    // Debounce stage: state, candidate, hold counter and accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_STABLE;
            cand     <= '0;
            cnt      <= '0;
            sw_clean <= '0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            cnt      <= cnt_nxt;
            sw_clean <= clean_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        clean_nxt = sw_clean;
        upd       = 1'b0;
        delta     = '0;
        if (sync_q != cand) begin
            // Any movement, including a bounce mid-settle, restarts the hold window
            cand_nxt  = sync_q;
            cnt_nxt   = '0;
            state_nxt = ST_SETTLE;
        end else if (state == ST_SETTLE) begin
            if (cnt != CNT_LAST) begin
                cnt_nxt = cnt + 1'b1;
            end else begin
                state_nxt = ST_STABLE;
                if (cand != sw_clean) begin
                    clean_nxt = cand;
                    upd       = 1'b1;
                    delta     = cand ^ sw_clean;
                end
            end
        end
    end

    // Event stage: a refused event absorbs later updates instead of dropping them
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_valid <= 1'b0;
            chg_bits  <= '0;
            chg_value <= '0;
        end else if (upd && (!chg_valid || chg_ready)) begin
            chg_valid <= 1'b1;
            chg_bits  <= delta;
            chg_value <= clean_nxt;
        end else if (upd) begin
            chg_bits  <= chg_bits | delta;
            chg_value <= clean_nxt;
        end else if (chg_valid && chg_ready) begin
            chg_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sw_debounce_events.sv
// Randomised and directed bench for sw_debounce_events with a run-length reference
// model and a handshake scoreboard.
module tb_sw_debounce_events;

    localparam int W      = 16;
    localparam int STABLE = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] SW = '0;
    logic         chg_ready = 1'b1;
    logic [W-1:0] sw_clean, chg_bits, chg_value;
    logic         chg_valid;

    int tests  = 0;
    int failed = 0;
    bit mon_en = 1'b0;

    // reference model state
    logic [W-1:0] m_clean = '0, m_bits = '0, m_value = '0;
    logic         m_valid = 1'b0;
    logic [W-1:0] run_val = '0;
    int           run_len = 0;
    bit           run_done = 1'b1;
    bit           pend_v [2];
    logic [W-1:0] pend_x [2];
    logic [W-1:0] exp_bits_q [$];
    logic [W-1:0] exp_value_q [$];

    sw_debounce_events #(
        .WIDTH         (W),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (SW),
        .sw_clean  (sw_clean),
        .chg_valid (chg_valid),
        .chg_ready (chg_ready),
        .chg_bits  (chg_bits),
        .chg_value (chg_value)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: a sampled value that persists for STABLE+1 consecutive edges is
    // accepted two edges later (synchroniser depth); reset forgets everything.
    initial begin
        pend_v[0] = 1'b0; pend_v[1] = 1'b0;
        pend_x[0] = '0;   pend_x[1] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_clean = '0; m_bits = '0; m_value = '0; m_valid = 1'b0;
                run_val = '0; run_len = 0; run_done = 1'b1;
                pend_v[0] = 1'b0; pend_v[1] = 1'b0;
            end else begin
                logic [W-1:0] nv;
                bit           u;
                u  = pend_v[0] && (pend_x[0] != m_clean);
                nv = pend_x[0];
                if (m_valid && chg_ready) begin
                    exp_bits_q.push_back(m_bits);
                    exp_value_q.push_back(m_value);
                end
                if (u) begin
                    if (!m_valid || chg_ready) m_bits = nv ^ m_clean;
                    else                       m_bits = m_bits | (nv ^ m_clean);
                    m_value = nv;
                    m_valid = 1'b1;
                    m_clean = nv;
                end else if (m_valid && chg_ready) begin
                    m_valid = 1'b0;
                end
                pend_v[0] = pend_v[1]; pend_x[0] = pend_x[1];
                pend_v[1] = 1'b0;
                if (SW != run_val) begin
                    run_val = SW; run_len = 1; run_done = 1'b0;
                end else begin
                    run_len++;
                end
                if (!run_done && run_len == STABLE + 1) begin
                    pend_v[1] = 1'b1; pend_x[1] = run_val; run_done = 1'b1;
                end
            end
        end
    end

    // Monitor: level/valid every cycle, event payload popped at each handshake
    initial begin
        logic [W-1:0] ob, ov;
        bit hs;
        forever begin
            @(negedge clk);
            hs = 1'b0;
            if (mon_en) begin
                check("sw_clean", sw_clean, m_clean);
                check("chg_valid", {15'd0, chg_valid}, {15'd0, m_valid});
                if (!rst && chg_valid && chg_ready) begin
                    hs = 1'b1; ob = chg_bits; ov = chg_value;
                end
            end
            @(posedge clk);
            #1;
            if (hs) begin
                if (exp_bits_q.size() == 0) begin
                    tests++; failed++;
                    $display("FAIL handshake: got bits %h value %h expected no event", ob, ov);
                end else begin
                    check("hs_bits", ob, exp_bits_q.pop_front());
                    check("hs_value", ov, exp_value_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // reset state
        step(3);
        mon_en = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (i % 10 == 0) begin
                check("rst_clean", sw_clean, '0);
                check("rst_valid", {15'd0, chg_valid}, '0);
                check("rst_bits", chg_bits, '0);
            end
        end

        // clean step with consumer ready
        SW = 16'h0005;
        step(10); check("step_early", sw_clean, 16'h0000);
        step(1);
        check("step_clean", sw_clean, 16'h0005);
        check("step_valid", {15'd0, chg_valid}, 16'h0001);
        check("step_bits", chg_bits, 16'h0005);
        check("step_value", chg_value, 16'h0005);
        step(1); check("step_drop", {15'd0, chg_valid}, '0);

        SW = 16'h0000; step(14);

        // bounce on bit0
        SW = 16'h0001; step(3);
        SW = 16'h0000; step(3);
        SW = 16'h0001;
        step(10); check("bounce_early", sw_clean, 16'h0000);
        step(1);  check("bounce_clean", sw_clean, 16'h0001);
        step(4);
        SW = 16'h0000; step(14);

        // coalescing while consumer stalls
        chg_ready = 1'b0;
        SW = 16'h0001; step(14);
        check("coal_bits1", chg_bits, 16'h0001);
        SW = 16'h0003; step(14);
        check("coal_valid", {15'd0, chg_valid}, 16'h0001);
        check("coal_bits", chg_bits, 16'h0003);
        check("coal_value", chg_value, 16'h0003);
        chg_ready = 1'b1; step(1);
        check("coal_done", {15'd0, chg_valid}, '0);
        SW = 16'h0000; step(14);

        // toggle there and back while stalled
        chg_ready = 1'b0;
        SW = 16'h0001; step(14);
        SW = 16'h0000; step(14);
        check("round_bits", chg_bits, 16'h0001);
        check("round_value", chg_value, 16'h0000);
        chg_ready = 1'b1; step(2);

        // reset mid-settle
        SW = 16'hFFFF; step(6);
        rst = 1'b1; step(1);
        check("mid_rst_clean", sw_clean, '0);
        check("mid_rst_bits", chg_bits, '0);
        step(1);
        rst = 1'b0;
        step(10); check("post_rst_early", sw_clean, '0);
        step(1);
        check("post_rst_clean", sw_clean, 16'hFFFF);
        check("post_rst_bits", chg_bits, 16'hFFFF);
        step(3);

        // randomised switching, bouncing, stalls and occasional resets
        for (int seg = 0; seg < 120; seg++) begin
            int hold;
            if ($urandom_range(0, 3) == 0) SW = 16'($urandom);
            else                           SW = SW ^ (16'h0001 << $urandom_range(0, 15));
            hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : $urandom_range(10, 16);
            for (int c = 0; c < hold; c++) begin
                chg_ready = ($urandom_range(0, 3) != 0);
                rst = ($urandom_range(0, 150) == 0);
                step(1);
            end
            rst = 1'b0;
        end

        chg_ready = 1'b1;
        step(30);
        check("queue_empty", 16'(exp_bits_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
